alu_multicycle: RTL

Parametrised multi-cycle execute-stage ALU, the successor to the single-cycle add/sub/and/or unit. It adds XOR, set-less-than, shifts, iterative multiply and unsigned divide/remainder, registered status flags, and a valid/ready handshake. Single-cycle operations complete in one clock. MUL/DIVU/REMU run a WIDTH-step iterative datapath and stall the issuing pipeline through `in_ready`.

---
 rtl/alu_multicycle.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD..SRA, plus iterative MUL/DIVU/REMU.
// Handshake: an op is accepted on a rising edge where in_valid && in_ready && !flush; out_valid pulses for one cycle per completion.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       ALUControlE,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [1:0]       dbg_state
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, is_multi, last_step, div_ge;
  logic [SHW-1:0]   count;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mcand, mplier, acc, divisor, quo, rem;
  logic [WIDTH-1:0] b_eff, sc_res, mc_res;
  logic [WIDTH:0]   sum, rem_sh;
  logic             is_sub, sc_carry, sc_ovf;

  assign accept    = in_valid && in_ready && !flush;
  assign is_multi  = ALUControlE inside {OP_MUL, OP_DIVU, OP_REMU};
  assign last_step = (count == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && is_multi) state_nxt = (ALUControlE == OP_MUL) ? MUL : DIV;
      MUL, DIV: if (last_step) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    dbg_state = state;
  end

  // One adder serves ADD and SUB; SUB is A + ~B + 1 so carry=1 means no borrow.
  always_comb begin
    is_sub   = (ALUControlE == OP_SUB);
    b_eff    = is_sub ? ~SrcBE : SrcBE;
    sum      = {1'b0, SrcAE} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ALUControlE)
      OP_ADD, OP_SUB: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (SrcAE[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcAE[WIDTH-1]);
      end
      OP_AND:  sc_res = SrcAE & SrcBE;
      OP_OR:   sc_res = SrcAE | SrcBE;
      OP_XOR:  sc_res = SrcAE ^ SrcBE;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (SrcAE < SrcBE)};
      OP_SLL:  sc_res = SrcAE << SrcBE[SHW-1:0];
      OP_SRL:  sc_res = SrcAE >> SrcBE[SHW-1:0];
      OP_SRA:  sc_res = WIDTH'($signed(SrcAE) >>> SrcBE[SHW-1:0]);
      default: sc_res = '0;
    endcase
  end

  // Restoring divide: dividend bits shift out of quo's top into rem, quotient bits shift into quo's bottom.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    div_ge = (rem_sh >= {1'b0, divisor});
    case (op_q)
      OP_MUL:  mc_res = acc;
      OP_DIVU: mc_res = quo;
      default: mc_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      ALUResult <= '0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
      op_q      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      divisor   <= '0;
      quo       <= '0;
      rem       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q  <= ALUControlE;
          count <= '0;
          if (is_multi) begin
            mcand   <= SrcAE;
            mplier  <= SrcBE;
            acc     <= '0;
            divisor <= SrcBE;
            quo     <= SrcAE;
            rem     <= '0;
          end else begin
            ALUResult <= sc_res;
            zero      <= (sc_res == '0);
            neg       <= sc_res[WIDTH-1];
            carry     <= sc_carry;
            ovf       <= sc_ovf;
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        DIV: begin
          rem   <= div_ge ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], div_ge};
          count <= count + 1'b1;
        end
        DONE: if (!flush) begin
          ALUResult <= mc_res;
          zero      <= (mc_res == '0);
          neg       <= mc_res[WIDTH-1];
          carry     <= 1'b0;
          ovf       <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
